// File: rtl/servo_pkg.sv
// servo_pkg: shared types and constants for the RC servo/ESC PWM generator.
// The default MIN_US/PERIOD constants are also used by the radio pulse-width
// receiver, so the transmit and receive width mappings cannot drift apart.
package servo_pkg;

  localparam int CMD_W              = 10;   // command width, 0..1023
  localparam int W_W                = 11;   // pulse width register, max 988+1023 = 2011
  localparam int DEF_MIN_US         = 988;  // pulse width for command 0
  localparam int DEF_PERIOD         = 3000; // frame length in 1 us ticks
  localparam int DEF_TIMEOUT_FRAMES = 10;
  localparam int DEF_FAILSAFE_VAL   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Pulse width in ticks for a command; 11 bits cannot overflow here.
  function automatic logic [W_W-1:0] pulse_width(input int min_us,
                                                 input logic [CMD_W-1:0] cmd);
    return W_W'(min_us) + W_W'(cmd);
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// frame_timer: modulo-PERIOD tick counter for the servo frame.
// Ports:
//   clk   in   tick clock (1 MHz)
//   rst_n in   asynchronous active-low reset
//   clr   in   hold the counter at 0 while high
//   cnt   out  position within the frame, 0..PERIOD-1
//   last  out  high while cnt == PERIOD-1 (counter wraps on the next edge)
module frame_timer
  import servo_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr || last)  cnt <= '0;
    else                   cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/servo.sv
// servo: RC servo/ESC PWM generator. Emits one pulse of MIN_US + val ticks
// at the start of every PERIOD-tick frame. Commands are double-buffered
// (pend -> act_w) and only take effect at frame start, so pulses are never
// torn. Dropping en lets the current frame finish before going idle.
// Ports:
//   clk_1M in   1 MHz tick clock
//   rst_n  in   asynchronous active-low reset
//   en     in   run the output while high
//   val    in   10-bit command
//   upd    in   strobe: capture val into the pending register
//   pwm    out  registered pulse output
//   frame  out  one-cycle strobe at each frame start (rises with pwm)
//   stale  out  failsafe active (constant 0 unless the failsafe is built)
// Build option: define SERVO_FAILSAFE_EN to substitute FAILSAFE_VAL after
// TIMEOUT_FRAMES consecutive frames without an upd strobe.
module servo
  import servo_pkg::*;
#(
  parameter int PERIOD         = DEF_PERIOD,
  parameter int MIN_US         = DEF_MIN_US,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES,
  parameter int FAILSAFE_VAL   = DEF_FAILSAFE_VAL
) (
  input  logic             clk_1M,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CMD_W-1:0] val,
  input  logic             upd,
  output logic             pwm,
  output logic             frame,
  output logic             stale
);

  localparam int CNT_W = $clog2(PERIOD);

  // Parameter sanity: the longest pulse must fit inside a frame.
  if (PERIOD < MIN_US + 1024) begin : g_bad_period
    $error("servo: PERIOD must be >= MIN_US+1024");
  end
  if (TIMEOUT_FRAMES < 1) begin : g_bad_timeout
    $error("servo: TIMEOUT_FRAMES must be >= 1");
  end
  if (FAILSAFE_VAL < 0 || FAILSAFE_VAL > 1023) begin : g_bad_failsafe
    $error("servo: FAILSAFE_VAL out of range");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             tmr_clr;
  logic             start;
  logic [CMD_W-1:0] pend;
  logic [CMD_W-1:0] cmd_sel;
  logic [W_W-1:0]   act_w;
  logic [W_W-1:0]   w_eff;

  assign tmr_clr = (state == IDLE);

  frame_timer #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_timer (
    .clk   (clk_1M),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .cnt   (cnt),
    .last  (last)
  );

  // Frame start only happens while running; DRAIN never sees cnt == 0.
  assign start = (state == RUN) && (cnt == '0);

  // At frame start the new width is used directly so the first pulse tick
  // compares against the value being loaded into act_w.
  assign w_eff = start ? pulse_width(MIN_US, cmd_sel) : act_w;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (en) state_nxt = RUN;
      // Losing en on the final tick: the frame is already complete.
      RUN:   if (!en) state_nxt = last ? IDLE : DRAIN;
      DRAIN: if (en)        state_nxt = RUN;
             else if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      act_w <= W_W'(MIN_US);
      pwm   <= 1'b0;
      frame <= 1'b0;
    end else begin
      state <= state_nxt;
      // pend feeds act_w via the old value, so a coincident upd lands a frame later.
      if (upd)   pend  <= val;
      if (start) act_w <= w_eff;
      pwm   <= (state != IDLE) && (32'(cnt) < 32'(w_eff));
      frame <= start;
    end
  end

`ifdef SERVO_FAILSAFE_EN
  localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);

  logic [MISS_W-1:0] miss;
  logic              seen;   // upd observed since the previous frame start

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      miss  <= '0;
      seen  <= 1'b0;
      stale <= 1'b0;
    end else begin
      if (upd) begin
        miss  <= '0;
        stale <= 1'b0;
      end else if (start && !seen && miss != MISS_W'(TIMEOUT_FRAMES)) begin
        miss <= miss + MISS_W'(1);
        if (miss == MISS_W'(TIMEOUT_FRAMES - 1)) stale <= 1'b1;
      end
      // A strobe coincident with frame start counts toward the next frame.
      if (start)    seen <= upd;
      else if (upd) seen <= 1'b1;
    end
  end

  assign cmd_sel = stale ? CMD_W'(FAILSAFE_VAL) : pend;
`else
  assign stale   = 1'b0;
  assign cmd_sel = pend;
`endif

endmodule

// File: tb/tb_servo.sv
module tb_servo;
  localparam int P = 3000;

  logic       clk_1M = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic [9:0] val    = '0;
  logic       upd    = 1'b0;
  logic       pwm, frame, stale;

  int checks = 0;
  int errors = 0;
  int exp_q[$];       // expected pulse widths, in emission order
  bit have_last = 0;  // period check armed (cleared across intentional gaps)

  servo dut (
    .clk_1M (clk_1M),
    .rst_n  (rst_n),
    .en     (en),
    .val    (val),
    .upd    (upd),
    .pwm    (pwm),
    .frame  (frame),
    .stale  (stale)
  );

  always #5 clk_1M = ~clk_1M;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic issue_upd(input int v);
    val = 10'(v);
    upd = 1'b1;
    @(negedge clk_1M);
    upd = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk_1M);
      n++;
    end while (!frame && n < 2 * P);
    chk("frame_wait", int'(frame), 1);
  endtask

  // Monitor: measures each completed pulse and frame period.
  initial begin
    int  hi    = 0;
    int  since = 0;
    bit  prev  = 0;
    forever begin
      @(negedge clk_1M);
      if (!rst_n) begin
        hi = 0; since = 0; prev = 0;
        continue;
      end
      since++;
      if (frame) begin
        if (have_last) chk("period", since, P);
        have_last = 1;
        since = 0;
      end
      if (pwm) hi++;
      else if (prev) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", hi, 0);
        else                   chk("width", hi, exp_q.pop_front());
        hi = 0;
      end
      prev = pwm;
    end
  end

  initial begin
    int vals[4] = '{12, 512, 1012, 1023};
    int wids[4] = '{1000, 1500, 2000, 2011};
    int nfr;
    int n;

    // Reset state
    repeat (3) @(negedge clk_1M);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_stale", int'(stale), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_1M);
    chk("idle_pwm", int'(pwm), 0);
    chk("idle_frame", int'(frame), 0);

    // Enable latency: pwm and frame rise two edges after en is sampled
    exp_q.push_back(988);
    en = 1'b1;
    @(negedge clk_1M);
    chk("en_lat1_pwm", int'(pwm), 0);
    @(negedge clk_1M);
    chk("en_lat2_pwm", int'(pwm), 1);
    chk("en_lat2_frame", int'(frame), 1);

    // Width table, one command per frame
    for (int i = 0; i < 4; i++) begin
      issue_upd(vals[i]);
      exp_q.push_back(wids[i]);
      wait_frame();
    end

    // Two strobes in one frame: last one wins (988+700)
    issue_upd(100);
    repeat (500) @(negedge clk_1M);
    issue_upd(700);
    exp_q.push_back(1688);
    wait_frame();
    exp_q.push_back(1688);

    // upd in the frame-start cycle (cnt == 0): current frame keeps 700
    repeat (P - 1) @(negedge clk_1M);
    val = 10'd300;
    upd = 1'b1;
    @(negedge clk_1M);
    upd = 1'b0;
    chk("coinc_frame", int'(frame), 1);
    exp_q.push_back(1288);
    wait_frame();

    // Drain: en dropped at cnt 500 of a 2000-tick pulse
    issue_upd(1012);
    exp_q.push_back(2000);
    wait_frame();
    repeat (499) @(negedge clk_1M);
    en = 1'b0;
    nfr = 0;
    repeat (P - 500 + 100) begin
      @(negedge clk_1M);
      if (frame) nfr++;
    end
    chk("drain_noframe", nfr, 0);
    chk("drain_pwm", int'(pwm), 0);

    // Re-enable, then en glitch low inside DRAIN: no frame gap
    have_last = 0;
    exp_q.push_back(2000);
    en = 1'b1;
    wait_frame();
    repeat (2099) @(negedge clk_1M);
    en = 1'b0;
    repeat (200) @(negedge clk_1M);
    en = 1'b1;
    wait_frame();

    // Asynchronous reset mid-pulse (cnt 1200)
    repeat (1199) @(negedge clk_1M);
    chk("pre_rst_pwm", int'(pwm), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_pwm", int'(pwm), 0);
    en = 1'b0;
    have_last = 0;
    @(negedge clk_1M);
    chk("rst2_frame", int'(frame), 0);
    chk("rst2_stale", int'(stale), 0);
    @(negedge clk_1M);
    rst_n = 1'b1;
    nfr = 0;
    repeat (20) begin
      @(negedge clk_1M);
      if (frame) nfr++;
    end
    chk("post_rst_noframe", nfr, 0);

    // Command loaded while idle, then run
    issue_upd(512);
    exp_q.push_back(1500);
    en = 1'b1;
    wait_frame();
`ifdef SERVO_FAILSAFE_EN
    for (int f = 2; f <= 11; f++) begin
      exp_q.push_back(1500);
      wait_frame();
      if (f == 10) chk("stale_before", int'(stale), 0);
      if (f == 11) chk("stale_set", int'(stale), 1);
    end
    exp_q.push_back(988);
    wait_frame();
    issue_upd(512);
    chk("stale_clear", int'(stale), 0);
    exp_q.push_back(1500);
    wait_frame();
`else
    chk("stale_off", int'(stale), 0);
`endif

    // Let the last pulse finish and confirm every expected pulse appeared
    en = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * P) begin
      @(negedge clk_1M);
      n++;
    end
    chk("queue_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
